// File: rtl/ocx_dlx_flit_buf_pkg.sv
// Shared defaults and types for the DLX flit buffer controller.
package ocx_dlx_flit_buf_pkg;
  localparam int DEF_DATA_W     = 512;
  localparam int DEF_ADDR_W     = 7;
  localparam int DEF_RD_LAT     = 2;
  localparam int DEF_SKID_DEPTH = 4;
  localparam int DEF_AFULL_THR  = 120;

  // Wrap-bit pointer compare result.
  typedef struct packed {
    logic full;
    logic empty;
  } ptr_st_t;
endpackage

// File: rtl/ocx_dlx_flit_skid.sv
// Small register FIFO that re-times BRAM read data toward the TL consumer.
module ocx_dlx_flit_skid #(
  parameter int DATA_W = 512,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [DATA_W-1:0]            din_i,
  input  logic                         pop_i,
  output logic [$clog2(DEPTH+1)-1:0]   occ_o,
  output logic [DATA_W-1:0]            head_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_q, rd_q, wr_d, rd_d;
  logic [OW-1:0]     occ_q, occ_d;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    occ_d = occ_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      occ_d = '0;
    end else begin
      if (push_i) wr_d = nxt(wr_q);
      if (pop_i)  rd_d = nxt(rd_q);
      occ_d = occ_q + OW'(push_i) - OW'(pop_i);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      occ_q <= occ_d;
    end
  end

  // Payload storage needs no reset; occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= din_i;
  end

  assign occ_o  = occ_q;
  assign head_o = mem_q[rd_q];
endmodule

// File: rtl/ocx_dlx_flit_buf_ctl.sv
// BRAM write/read controller: non-stalling RX writes, backpressured TL reads
// through an in-flight tracker and skid FIFO.
module ocx_dlx_flit_buf_ctl
  import ocx_dlx_flit_buf_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int RD_LAT     = DEF_RD_LAT,
  parameter int SKID_DEPTH = DEF_SKID_DEPTH,
  parameter int AFULL_THR  = DEF_AFULL_THR
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              bram_wea,
  output logic [ADDR_W-1:0] bram_addra,
  output logic [DATA_W-1:0] bram_dina,
  output logic              bram_enb,
  output logic [ADDR_W-1:0] bram_addrb,
  output logic              bram_rstb,
  input  logic [DATA_W-1:0] bram_doutb,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic              almost_full,
  output logic              overflow_err
);
  localparam int OCC_W = $clog2(SKID_DEPTH+1);

  logic [ADDR_W:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [RD_LAT-1:0] vld_pipe_q, vld_pipe_d;
  logic              ovf_q, ovf_d, rstb_q;
  ptr_st_t           ptr_st;
  logic              wr, rd, push, pop;
  logic [OCC_W-1:0]  skid_occ;
  logic [OCC_W:0]    occ_sum;

  always_comb begin
    ptr_st.empty = (wptr_q == rptr_q);
    ptr_st.full  = (wptr_q[ADDR_W] != rptr_q[ADDR_W]) &&
                   (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);
  end

  // Reserve skid space for every read already launched.
  always_comb begin
    occ_sum = (OCC_W+1)'(skid_occ);
    for (int i = 0; i < RD_LAT; i++) occ_sum = occ_sum + (OCC_W+1)'(vld_pipe_q[i]);
  end

  assign wr   = in_valid && !ptr_st.full && !flush;
  assign rd   = !ptr_st.empty && (occ_sum < (OCC_W+1)'(SKID_DEPTH)) && !flush;
  assign push = vld_pipe_q[RD_LAT-1];
  assign pop  = out_valid && out_ready;

  always_comb begin
    wptr_d     = wptr_q + (ADDR_W+1)'(wr);
    rptr_d     = rptr_q + (ADDR_W+1)'(rd);
    ovf_d      = ovf_q | (in_valid && ptr_st.full && !flush);
    vld_pipe_d = '0;
    vld_pipe_d[0] = rd;
    for (int i = 1; i < RD_LAT; i++) vld_pipe_d[i] = vld_pipe_q[i-1];
    if (flush) begin
      wptr_d     = '0;
      rptr_d     = '0;
      vld_pipe_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      vld_pipe_q <= '0;
      ovf_q      <= 1'b0;
      rstb_q     <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      vld_pipe_q <= vld_pipe_d;
      ovf_q      <= ovf_d;
      rstb_q     <= flush;
    end
  end

  ocx_dlx_flit_skid #(.DATA_W(DATA_W), .DEPTH(SKID_DEPTH)) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .flush_i (flush),
    .push_i  (push),
    .din_i   (bram_doutb),
    .pop_i   (pop),
    .occ_o   (skid_occ),
    .head_o  (out_data)
  );

  assign bram_wea     = wr;
  assign bram_addra   = wptr_q[ADDR_W-1:0];
  assign bram_dina    = in_data;
  assign bram_enb     = rd;
  assign bram_addrb   = rptr_q[ADDR_W-1:0];
  assign bram_rstb    = rstb_q;
  assign out_valid    = (skid_occ != '0);
  assign count        = wptr_q - rptr_q;
  assign almost_full  = (count >= (ADDR_W+1)'(AFULL_THR));
  assign overflow_err = ovf_q;
endmodule

// File: tb/tb_ocx_dlx_flit_buf_ctl.sv
// Randomized bench for the flit buffer controller against a queue-based model
// of stored, in-flight and skid flits, with a 2-cycle BRAM model.
module tb_ocx_dlx_flit_buf_ctl;
  localparam int DW = 512, AW = 7, RD_LAT = 2, SKID = 4, THR = 120, DEPTH = 128;

  logic          clk, reset_n, flush, in_valid, out_ready;
  logic [DW-1:0] in_data, bram_dina, bram_doutb, out_data;
  logic          bram_wea, bram_enb, bram_rstb, out_valid, almost_full, overflow_err;
  logic [AW-1:0] bram_addra, bram_addrb;
  logic [AW:0]   count;

  ocx_dlx_flit_buf_ctl dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .bram_wea(bram_wea), .bram_addra(bram_addra), .bram_dina(bram_dina),
    .bram_enb(bram_enb), .bram_addrb(bram_addrb), .bram_rstb(bram_rstb),
    .bram_doutb(bram_doutb), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .count(count), .almost_full(almost_full),
    .overflow_err(overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM: read registered twice, old data on same-address collision.
  logic [DW-1:0] bmem [DEPTH];
  logic [DW-1:0] bp1;
  always @(posedge clk) begin
    if (bram_wea) bmem[bram_addra] <= bram_dina;
    if (bram_enb) bp1 <= bmem[bram_addrb];
    if (bram_rstb) bram_doutb <= '0;
    else           bram_doutb <= bp1;
  end

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Model: flits stored in BRAM, reads launched but not returned, skid contents.
  logic [DW-1:0] m_mem[$];
  logic [DW-1:0] m_skid[$];
  logic          pv [RD_LAT];
  logic [DW-1:0] pd [RD_LAT];
  logic          m_ovf, m_rstb;
  logic          last_ov, last_enb, last_wea;
  logic [DW-1:0] last_od;

  task automatic mdl_reset();
    m_mem.delete();
    m_skid.delete();
    for (int i = 0; i < RD_LAT; i++) begin pv[i] = 1'b0; pd[i] = '0; end
    m_ovf  = 1'b0;
    m_rstb = 1'b0;
  endtask

  task automatic mdl_flush();
    m_mem.delete();
    m_skid.delete();
    for (int i = 0; i < RD_LAT; i++) pv[i] = 1'b0;
  endtask

  // Called just after a rising edge; drives, checks at the falling edge, advances model.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic rdy, input logic fl);
    int  npipe;
    logic full, issue, wr, ov;
    in_valid = v; in_data = d; out_ready = rdy; flush = fl;
    @(negedge clk);
    npipe = 0;
    for (int i = 0; i < RD_LAT; i++) npipe += int'(pv[i]);
    full  = (m_mem.size() == DEPTH);
    issue = (m_mem.size() > 0) && (npipe + m_skid.size() < SKID) && !fl;
    wr    = v && !full && !fl;
    ov    = (m_skid.size() > 0);
    chk("wea", bram_wea, wr);
    chk("enb", bram_enb, issue);
    chk("out_valid", out_valid, ov);
    if (ov) chk("out_data", out_data, m_skid[0]);
    chk("count", count, m_mem.size());
    chk("almost_full", almost_full, m_mem.size() >= THR);
    chk("overflow_err", overflow_err, m_ovf);
    chk("rstb", bram_rstb, m_rstb);
    last_ov = out_valid; last_enb = bram_enb; last_wea = bram_wea; last_od = out_data;
    m_rstb = fl;
    if (fl) mdl_flush();
    else begin
      if (v && full) m_ovf = 1'b1;
      if (ov && rdy) void'(m_skid.pop_front());
      if (pv[RD_LAT-1]) m_skid.push_back(pd[RD_LAT-1]);
      for (int i = RD_LAT-1; i > 0; i--) begin pv[i] = pv[i-1]; pd[i] = pd[i-1]; end
      pv[0] = issue;
      pd[0] = issue ? m_mem.pop_front() : '0;
      if (wr) m_mem.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_ov"},    out_valid, 1'b0);
    chk({tag, "_cnt"},   count, '0);
    chk({tag, "_wea"},   bram_wea, 1'b0);
    chk({tag, "_enb"},   bram_enb, 1'b0);
    chk({tag, "_rstb"},  bram_rstb, 1'b0);
    chk({tag, "_afull"}, almost_full, 1'b0);
    chk({tag, "_ovf"},   overflow_err, 1'b0);
  endtask

  // Write captured at edge T, read launched in the following cycle, out_valid
  // rises at edge T+1+RD_LAT: seen RD_LAT+2 sampled cycles after the write.
  task automatic lat_test(input string tag, input logic [DW-1:0] d);
    int k;
    step(1'b1, d, 1'b1, 1'b0);
    chk({tag, "_wea"}, last_wea, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    k = 1;
    chk({tag, "_enb"}, last_enb, 1'b1);
    while (!last_ov && k < 12) begin
      step(1'b0, '0, 1'b1, 1'b0);
      k++;
    end
    chk({tag, "_lat"}, k, RD_LAT + 2);
    chk({tag, "_data"}, last_od, d);
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] r;
    for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  initial begin
    reset_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    mdl_reset();
    #1 reset_n = 1'b0;
    #2 rst_chk("rst0");
    @(posedge clk); #3 reset_n = 1'b1;
    @(posedge clk); #1;

    lat_test("single_a5", {64{8'hA5}});

    // Fill past full with the consumer stalled.
    for (int i = 0; i < 140; i++) step(1'b1, rnd(), 1'b0, 1'b0);
    chk("fill_ovf", overflow_err, 1'b1);
    chk("fill_cnt", count, DEPTH);

    // Drain a little so reads are in flight, then flush.
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, rnd(), 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    lat_test("flush_5a", {64{8'h5A}});

    // Stream of 300 flits, consumer toggling; wraps the address space twice.
    begin
      int sent = 0;
      int cyc = 0;
      while (sent < 300) begin
        logic v;
        v = ($urandom_range(0, 2) != 0);
        step(v, rnd(), cyc[0] == 1'b0, 1'b0);
        sent += int'(v);
        cyc++;
      end
    end
    for (int i = 0; i < 400; i++) step(1'b0, '0, i[0], 1'b0);
    chk("stream_cnt", count, '0);

    // Random traffic with occasional flush; bias the consumer slow in bursts.
    for (int i = 0; i < 1500; i++) begin
      logic rdy;
      rdy = ((i / 200) % 2 == 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
      step($urandom_range(0, 3) != 0, rnd(), rdy, $urandom_range(0, 149) == 0);
    end

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 10; i++) step(1'b1, rnd(), 1'b0, 1'b0);
    #2 in_valid = 1'b0; reset_n = 1'b0;
    #1 rst_chk("rst_mid");
    mdl_reset();
    @(posedge clk); #3 reset_n = 1'b1;
    @(posedge clk); #1;
    lat_test("post_rst_77", {64{8'h77}});
    for (int i = 0; i < 20; i++) step($urandom_range(0, 1) == 1, rnd(), 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
